// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the EX->ID forwarding and load-use stall unit:
// forwarding source encoding, the hard-wired zero register and FSM states.
package hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_src_t;

  // $0 is hard-wired; a write to it must never be forwarded or stall.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority compare for one ID operand against the EX, MEM and WB writers.
// Purely combinational; EX beats MEM beats WB.
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_uses,
  input  logic [REG_ADDR_W-1:0] i_ex_dest,
  input  logic                  i_ex_wr,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic                  i_mem_wr,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic                  i_wb_wr,
  output fwd_src_t              o_sel,
  output logic                  o_ex_match
);

  logic [REG_ADDR_W-1:0] w_zero;
  logic                  w_src_live;
  logic                  w_mem_match;
  logic                  w_wb_match;

  assign w_zero      = REG_ADDR_W'(REG_ZERO);
  assign w_src_live  = i_uses && (i_src != w_zero);
  assign o_ex_match  = w_src_live && i_ex_wr  && (i_ex_dest  == i_src);
  assign w_mem_match = w_src_live && i_mem_wr && (i_mem_dest == i_src);
  assign w_wb_match  = w_src_live && i_wb_wr  && (i_wb_dest  == i_src);

  // NOTE: defaulting o_sel first keeps every path assigned, so no latch is inferred.
  always_comb begin
    o_sel = FWD_RF;
    if (o_ex_match)       o_sel = FWD_EX;
    else if (w_mem_match) o_sel = FWD_MEM;
    else if (w_wb_match)  o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects and load-use stall/bubble generation for the ID stage.
// Optional HAZARD_STALL_COUNT_EN adds a 16-bit saturating stall-cycle counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_uses_rs,
  input  logic                  ID_uses_rt,
  input  logic [REG_ADDR_W-1:0] EX_dest,
  input  logic                  EX_rf_enable,
  input  logic                  EX_load_instr,
  output logic [1:0]            fwdA_sel,
  output logic [1:0]            fwdB_sel,
  output logic                  stall,
  output logic                  bubble
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic                  r_mem_wr;
  logic [REG_ADDR_W-1:0] r_wb_dest;
  logic                  r_wb_wr;
  fsm_state_t            r_state;
  logic [1:0]            r_cnt;

  fwd_src_t w_sel_a;
  fwd_src_t w_sel_b;
  logic     w_ex_match_a;
  logic     w_ex_match_b;
  logic     w_hazard;
  logic     w_stall;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_src      (ID_rs),
    .i_uses     (ID_uses_rs),
    .i_ex_dest  (EX_dest),
    .i_ex_wr    (EX_rf_enable),
    .i_mem_dest (r_mem_dest),
    .i_mem_wr   (r_mem_wr),
    .i_wb_dest  (r_wb_dest),
    .i_wb_wr    (r_wb_wr),
    .o_sel      (w_sel_a),
    .o_ex_match (w_ex_match_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_src      (ID_rt),
    .i_uses     (ID_uses_rt),
    .i_ex_dest  (EX_dest),
    .i_ex_wr    (EX_rf_enable),
    .i_mem_dest (r_mem_dest),
    .i_mem_wr   (r_mem_wr),
    .i_wb_dest  (r_wb_dest),
    .i_wb_wr    (r_wb_wr),
    .o_sel      (w_sel_b),
    .o_ex_match (w_ex_match_b)
  );

  // A load's data is not ready in EX, so any EX match on it must stall instead.
  assign w_hazard = EX_load_instr && EX_rf_enable && (w_ex_match_a || w_ex_match_b);
  assign w_stall  = reset && ((r_state == STALL) || w_hazard);

  assign fwdA_sel = reset ? w_sel_a : FWD_RF;
  assign fwdB_sel = reset ? w_sel_b : FWD_RF;
  assign stall    = w_stall;
  assign bubble   = w_stall;

  // NOTE: only the valid bits are reset; stale dest values are harmless while
  // their wr bit is low, and non-blocking updates let the slots shift in one edge.
  always_ff @(posedge clk) begin
    r_mem_dest <= EX_dest;
    r_wb_dest  <= r_mem_dest;
    if (!reset) begin
      r_mem_wr <= 1'b0;
      r_wb_wr  <= 1'b0;
    end else begin
      r_mem_wr <= EX_rf_enable;
      r_wb_wr  <= r_mem_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard && (LOAD_STALL_CYCLES > 1)) begin
            r_state <= STALL;
            r_cnt   <= 2'(LOAD_STALL_CYCLES - 1);
          end
        end
        STALL: begin
          if (r_cnt <= 2'd1) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset)                                 r_stall_count <= 16'd0;
    else if (w_stall && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule
